video_timing_gen: RTL

Parametrised raster timing generator for the LCD/HDMI output path. It produces HS, VS and DE, plus a pixel-fetch request with a configurable lead and zero-based pixel coordinates for the upstream frame buffer reader. Timing is reprogrammable at runtime through shadow registers that are applied only on a frame boundary. A run/stop control finishes the current frame before idling.

---
 rtl/video_timing_gen.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: HS/VS/DE, lead-adjusted pixel requests and
// frame-boundary reprogramming through a validated shadow register set.
module video_timing_gen #(
    parameter int DATA_W   = 24,
    parameter int CNT_W    = 12,
    parameter int REQ_LEAD = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int H_SYNC   = 44,
    parameter int H_BACK   = 148,
    parameter int H_DISP   = 1920,
    parameter int H_FRONT  = 88,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 36,
    parameter int V_DISP   = 1080,
    parameter int V_FRONT  = 4
) (
    input  logic              pixel_clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic              cfg_wr,
    input  logic [CNT_W-1:0]  cfg_h_sync,
    input  logic [CNT_W-1:0]  cfg_h_back,
    input  logic [CNT_W-1:0]  cfg_h_disp,
    input  logic [CNT_W-1:0]  cfg_h_front,
    input  logic [CNT_W-1:0]  cfg_v_sync,
    input  logic [CNT_W-1:0]  cfg_v_back,
    input  logic [CNT_W-1:0]  cfg_v_disp,
    input  logic [CNT_W-1:0]  cfg_v_front,
    output logic              cfg_pending,
    output logic              cfg_err,
    input  logic [DATA_W-1:0] pixel_data,
    output logic              data_req,
    output logic [CNT_W-1:0]  pixel_xpos,
    output logic [CNT_W-1:0]  pixel_ypos,
    output logic              video_hs,
    output logic              video_vs,
    output logic              video_de,
    output logic [DATA_W-1:0] video_rgb,
    output logic              frame_start,
    output logic              line_start,
    output logic              busy
);

    localparam int TW = CNT_W + 2;
    localparam logic [TW-1:0] TMAX = TW'((64'd1 << CNT_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_h, cnt_v;
    logic [CNT_W-1:0] a_hs, a_hb, a_hd, a_hf, a_vs, a_vb, a_vd, a_vf;
    logic [CNT_W-1:0] s_hs, s_hb, s_hd, s_hf, s_vs, s_vb, s_vd, s_vf;

    function automatic logic [TW-1:0] sum4(
        input logic [CNT_W-1:0] a, b, c, d);
        return TW'(a) + TW'(b) + TW'(c) + TW'(d);
    endfunction

    logic [TW-1:0]    h_tot, v_tot, c_htot, c_vtot;
    logic [CNT_W-1:0] h_last, v_last;
    logic [TW-1:0]    hst, hend, vst, vend;
    logic [TW-1:0]    h_w, v_w, h_ahead, xdiff, ydiff;
    logic             last_px, v_in, de_d, req_d;
    logic             cfg_ok, wr_ok, apply;

    assign h_tot   = sum4(a_hs, a_hb, a_hd, a_hf);
    assign v_tot   = sum4(a_vs, a_vb, a_vd, a_vf);
    assign h_last  = h_tot[CNT_W-1:0] - CNT_W'(1);
    assign v_last  = v_tot[CNT_W-1:0] - CNT_W'(1);
    assign hst     = TW'(a_hs) + TW'(a_hb);
    assign hend    = hst + TW'(a_hd);
    assign vst     = TW'(a_vs) + TW'(a_vb);
    assign vend    = vst + TW'(a_vd);
    assign h_w     = TW'(cnt_h);
    assign v_w     = TW'(cnt_v);
    // Lookahead stays within the current line; needs sync+back >= REQ_LEAD.
    assign h_ahead = h_w + TW'(REQ_LEAD);
    assign xdiff   = h_ahead - hst;
    assign ydiff   = v_w - vst;
    assign last_px = (cnt_h == h_last) && (cnt_v == v_last);
    assign v_in    = (v_w >= vst) && (v_w < vend);
    assign de_d    = (h_w >= hst) && (h_w < hend) && v_in;
    assign req_d   = (h_ahead >= hst) && (h_ahead < hend) && v_in;

    assign c_htot = sum4(cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front);
    assign c_vtot = sum4(cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front);
    assign cfg_ok = (cfg_h_sync != '0) && (cfg_h_disp != '0) &&
                    (cfg_v_sync != '0) && (cfg_v_disp != '0) &&
                    (c_htot <= TMAX) && (c_vtot <= TMAX);
    assign wr_ok  = cfg_wr && cfg_ok;
    assign apply  = cfg_pending &&
                    ((state == IDLE) || last_px);

    // Shadow capture, validation and frame-boundary apply
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_hs <= CNT_W'(H_SYNC);  a_hb <= CNT_W'(H_BACK);
            a_hd <= CNT_W'(H_DISP);  a_hf <= CNT_W'(H_FRONT);
            a_vs <= CNT_W'(V_SYNC);  a_vb <= CNT_W'(V_BACK);
            a_vd <= CNT_W'(V_DISP);  a_vf <= CNT_W'(V_FRONT);
            s_hs <= '0; s_hb <= '0; s_hd <= '0; s_hf <= '0;
            s_vs <= '0; s_vb <= '0; s_vd <= '0; s_vf <= '0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !cfg_ok;
            if (apply) begin
                a_hs <= s_hs; a_hb <= s_hb; a_hd <= s_hd; a_hf <= s_hf;
                a_vs <= s_vs; a_vb <= s_vb; a_vd <= s_vd; a_vf <= s_vf;
            end
            if (wr_ok) begin
                s_hs <= cfg_h_sync; s_hb <= cfg_h_back;
                s_hd <= cfg_h_disp; s_hf <= cfg_h_front;
                s_vs <= cfg_v_sync; s_vb <= cfg_v_back;
                s_vd <= cfg_v_disp; s_vf <= cfg_v_front;
            end
            cfg_pending <= wr_ok || (cfg_pending && !apply);
        end
    end

    // Run/stop FSM with raster counters
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt_h <= '0;
            cnt_v <= '0;
        end else begin
            if (state == IDLE) begin
                cnt_h <= '0;
                cnt_v <= '0;
            end else if (cnt_h == h_last) begin
                cnt_h <= '0;
                cnt_v <= (cnt_v == v_last) ? '0 : cnt_v + CNT_W'(1);
            end else begin
                cnt_h <= cnt_h + CNT_W'(1);
            end
            unique case (state)
                IDLE: if (en) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (!en) state <= STOP;
                STOP: if (en) begin
                    state <= RUN;
                end else if (last_px) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered decode of the counter state
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            video_hs    <= !HS_POL;
            video_vs    <= !VS_POL;
            video_de    <= 1'b0;
            video_rgb   <= '0;
            data_req    <= 1'b0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (state == IDLE) begin
            video_hs    <= !HS_POL;
            video_vs    <= !VS_POL;
            video_de    <= 1'b0;
            video_rgb   <= '0;
            data_req    <= 1'b0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            video_hs    <= (cnt_h < a_hs) ? HS_POL : !HS_POL;
            video_vs    <= (cnt_v < a_vs) ? VS_POL : !VS_POL;
            video_de    <= de_d;
            video_rgb   <= de_d ? pixel_data : '0;
            data_req    <= req_d;
            pixel_xpos  <= req_d ? xdiff[CNT_W-1:0] : '0;
            pixel_ypos  <= req_d ? ydiff[CNT_W-1:0] : '0;
            frame_start <= (cnt_h == '0) && (cnt_v == '0);
            line_start  <= (cnt_h == '0);
        end
    end

endmodule
